// File: rtl/priority_frame_builder_pkg.sv
// -----------------------------------------------------------------------------
// priority_frame_builder_pkg
//   Shared constants for the passenger-priority frame builder: field widths,
//   counter widths, index width and the FSM state encodings.
//   No ports (package).
// -----------------------------------------------------------------------------
package priority_frame_builder_pkg;

   localparam int NP_W    = 32;   // np field width, received first, LSB first
   localparam int VIP_W   = 8;    // vip field width, received after np
   localparam int NP_CW   = 6;    // np_cnt width, holds 0..NP_W
   localparam int VIP_CW  = 4;    // vip_cnt width, holds 0..VIP_W
   localparam int FRAME_W = NP_W + VIP_W + 1;

   // One shared bit index walks both fields, so it is sized for the larger one.
   localparam int IDX_W   = $clog2(NP_W);
   localparam int VIP_IW  = $clog2(VIP_W);

   localparam logic [1:0] S_NP   = 2'd0;
   localparam logic [1:0] S_VIP  = 2'd1;
   localparam logic [1:0] S_VVIP = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

endpackage

// File: rtl/priority_frame_builder_if.sv
// -----------------------------------------------------------------------------
// priority_frame_builder_if
//   Bundles the serial bit input, the clear control and the parallel frame
//   output of the frame builder.
//
//   Handshakes (both strict valid/ready): a transfer happens on a rising clk
//   edge where valid and ready are both 1. The sender keeps valid (and its
//   data) until that edge; ready may change freely and never depends on valid.
//     - bit stream : bit_valid / bit_ready, payload bit_in
//     - frame out  : out_valid / out_ready, payload np/vip/vvip/np_cnt/vip_cnt
//
//   Modports
//     master : the builder (drives bit_ready and the frame)
//     slave  : the environment (drives bits, clear and out_ready)
// -----------------------------------------------------------------------------
interface priority_frame_builder_if import priority_frame_builder_pkg::*; ();

   logic                clear;
   logic                bit_in;
   logic                bit_valid;
   logic                bit_ready;
   logic [NP_W-1:0]     np;
   logic [VIP_W-1:0]    vip;
   logic                vvip;
   logic [NP_CW-1:0]    np_cnt;
   logic [VIP_CW-1:0]   vip_cnt;
   logic                out_valid;
   logic                out_ready;

   modport master (
      input  clear, bit_in, bit_valid, out_ready,
      output bit_ready, np, vip, vvip, np_cnt, vip_cnt, out_valid
   );

   modport slave (
      output clear, bit_in, bit_valid, out_ready,
      input  bit_ready, np, vip, vvip, np_cnt, vip_cnt, out_valid
   );

endinterface

// File: rtl/priority_frame_builder.sv
// -----------------------------------------------------------------------------
// priority_frame_builder
//   Serial-to-parallel producer for the passenger-priority comparator.
//   Accepts one bit per bit_valid && bit_ready cycle, assembling np (NP_W bits,
//   LSB first), then vip (VIP_W bits, LSB first), then vvip. Running set-bit
//   counts for np and vip are kept as bits arrive. The completed frame is held
//   on out_valid until out_ready is seen.
//
//   Ports
//     clk       in   system clock, all state on posedge
//     reset     in   synchronous active-high reset, beats every other input
//     bus       --   priority_frame_builder_if.master (bits, clear, frame)
//     dbg_state out  current FSM state (S_NP/S_VIP/S_VVIP/S_HOLD)
// -----------------------------------------------------------------------------
module priority_frame_builder import priority_frame_builder_pkg::*; (
   input  logic                       clk,
   input  logic                       reset,
   priority_frame_builder_if.master   bus,
   output logic [1:0]                 dbg_state
);

   logic [1:0]          state_q,   state_d;
   logic [IDX_W-1:0]    idx_q,     idx_d;
   logic [NP_W-1:0]     np_q,      np_d;
   logic [VIP_W-1:0]    vip_q,     vip_d;
   logic                vvip_q,    vvip_d;
   logic [NP_CW-1:0]    np_cnt_q,  np_cnt_d;
   logic [VIP_CW-1:0]   vip_cnt_q, vip_cnt_d;

   logic accept;
   logic zero_all;

   // bit_ready is decoded from the state flop only, so it never depends on
   // bit_valid and the bit stream cannot form a combinational loop.
   assign accept = bus.bit_valid && (state_q != S_HOLD);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      np_d      = np_q;
      vip_d     = vip_q;
      vvip_d    = vvip_q;
      np_cnt_d  = np_cnt_q;
      vip_cnt_d = vip_cnt_q;
      zero_all  = 1'b0;

      if (bus.clear) begin
         // clear wins over both an offered bit and a pending handshake.
         zero_all = 1'b1;
      end else begin
         case (state_q)
            S_NP: begin
               if (accept) begin
                  np_d[idx_q] = bus.bit_in;
                  np_cnt_d    = np_cnt_q + NP_CW'(bus.bit_in);
                  if (idx_q == IDX_W'(NP_W - 1)) begin
                     idx_d   = '0;
                     state_d = S_VIP;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            S_VIP: begin
               if (accept) begin
                  vip_d[idx_q[VIP_IW-1:0]] = bus.bit_in;
                  vip_cnt_d = vip_cnt_q + VIP_CW'(bus.bit_in);
                  if (idx_q == IDX_W'(VIP_W - 1)) begin
                     idx_d   = '0;
                     state_d = S_VVIP;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            S_VVIP: begin
               if (accept) begin
                  vvip_d  = bus.bit_in;
                  state_d = S_HOLD;
               end
            end
            S_HOLD: begin
               // Fields are frozen here; they only move on the handshake.
               if (bus.out_ready) begin
                  zero_all = 1'b1;
               end
            end
            default: begin
               zero_all = 1'b1;
            end
         endcase
      end

      if (zero_all) begin
         state_d   = S_NP;
         idx_d     = '0;
         np_d      = '0;
         vip_d     = '0;
         vvip_d    = 1'b0;
         np_cnt_d  = '0;
         vip_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_NP;
         idx_q     <= '0;
         np_q      <= '0;
         vip_q     <= '0;
         vvip_q    <= 1'b0;
         np_cnt_q  <= '0;
         vip_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         np_q      <= np_d;
         vip_q     <= vip_d;
         vvip_q    <= vvip_d;
         np_cnt_q  <= np_cnt_d;
         vip_cnt_q <= vip_cnt_d;
      end
   end

   assign bus.bit_ready = (state_q != S_HOLD);
   assign bus.out_valid = (state_q == S_HOLD);
   assign bus.np        = np_q;
   assign bus.vip       = vip_q;
   assign bus.vvip      = vvip_q;
   assign bus.np_cnt    = np_cnt_q;
   assign bus.vip_cnt   = vip_cnt_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_priority_frame_builder.sv
// -----------------------------------------------------------------------------
// tb_priority_frame_builder
//   Self-checking bench for priority_frame_builder. A frame-level model keeps
//   the list of bits accepted so far; expected fields are rebuilt from that
//   list and counts are plain popcounts. Completed frames go into exp_q and are
//   matched against the DUT on every output handshake.
// -----------------------------------------------------------------------------
module tb_priority_frame_builder;
   import priority_frame_builder_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   logic [1:0] dbg_state;
   always #5 clk = ~clk;

   priority_frame_builder_if bus_if ();

   priority_frame_builder dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus_if.master),
      .dbg_state (dbg_state)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // ---------------- model ----------------
   bit                 m_bits[$];
   bit                 m_hold = 1'b0;
   bit                 chk_en = 1'b0;
   logic [FRAME_W-1:0] exp_q[$];

   function automatic logic [31:0] exp_np();
      logic [31:0] r = '0;
      for (int i = 0; i < 32; i++)
         if (i < m_bits.size()) r[i] = m_bits[i];
      return r;
   endfunction

   function automatic logic [7:0] exp_vip();
      logic [7:0] r = '0;
      for (int i = 0; i < 8; i++)
         if (32 + i < m_bits.size()) r[i] = m_bits[32 + i];
      return r;
   endfunction

   function automatic logic exp_vvip();
      return (m_bits.size() > 40) ? m_bits[40] : 1'b0;
   endfunction

   function automatic logic [1:0] exp_state();
      if (m_hold)                 return 2'd3;
      else if (m_bits.size() < 32) return 2'd0;
      else if (m_bits.size() < 40) return 2'd1;
      else                         return 2'd2;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
         m_bits.delete();
         m_hold = 1'b0;
         exp_q.delete();
         chk_en = 1'b1;
      end else if (chk_en) begin
         if (bus_if.clear) begin
            if (m_hold && exp_q.size() > 0) void'(exp_q.pop_front());
            m_bits.delete();
            m_hold = 1'b0;
         end else if (m_hold) begin
            if (bus_if.out_ready) begin
               m_bits.delete();
               m_hold = 1'b0;
            end
         end else if (bus_if.bit_valid) begin
            m_bits.push_back(bus_if.bit_in);
            if (m_bits.size() == 41) begin
               m_hold = 1'b1;
               exp_q.push_back({exp_np(), exp_vip(), exp_vvip()});
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle compare against the model, plus the frame scoreboard.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("mon_np",        64'(bus_if.np),        64'(exp_np()));
         check("mon_vip",       64'(bus_if.vip),       64'(exp_vip()));
         check("mon_vvip",      64'(bus_if.vvip),      64'(exp_vvip()));
         check("mon_np_cnt",    64'(bus_if.np_cnt),    64'($countones(exp_np())));
         check("mon_vip_cnt",   64'(bus_if.vip_cnt),   64'($countones(exp_vip())));
         check("mon_out_valid", 64'(bus_if.out_valid), 64'(m_hold));
         check("mon_bit_ready", 64'(bus_if.bit_ready), 64'(!m_hold));
         check("mon_state",     64'(dbg_state),        64'(exp_state()));
         if (bus_if.out_valid && bus_if.out_ready && !bus_if.clear && !reset) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_frame", 64'(1), 64'(0));
            end else begin
               logic [FRAME_W-1:0] e;
               e = exp_q.pop_front();
               check("sb_frame", 64'({bus_if.np, bus_if.vip, bus_if.vvip}), 64'(e));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one bit and waits (bounded) until it is taken; returns the edge number.
   task automatic send_bit(input logic b, output int acc_cyc);
      bit done = 1'b0;
      int waited = 0;
      bus_if.bit_in    = b;
      bus_if.bit_valid = 1'b1;
      while (!done) begin
         done = bus_if.bit_ready;
         tick();
         if (!done) begin
            waited++;
            if (waited > 50) begin
               check("send_bit_timeout", 64'(waited), 64'(0));
               done = 1'b1;
            end
         end
      end
      acc_cyc = cyc;
      bus_if.bit_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] np, input logic [7:0] vip, input logic vvip,
                             input int gap, output int first_acc);
      logic [40:0] fr;
      int acc;
      fr = {vvip, vip, np};
      first_acc = 0;
      for (int i = 0; i < 41; i++) begin
         send_bit(fr[i], acc);
         if (i == 0) first_acc = acc;
         for (int g = 0; g < gap; g++) begin
            bus_if.bit_valid = 1'b0;
            bus_if.bit_in    = 1'($urandom_range(0, 1));
            tick();
         end
      end
   endtask

   task automatic handshake();
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.out_ready = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t0, acc, a_end;
      reset            = 1'b1;
      bus_if.clear     = 1'b0;
      bus_if.bit_in    = 1'b0;
      bus_if.bit_valid = 1'b0;
      bus_if.out_ready = 1'b0;
      repeat (3) tick();
      check("rst_out_valid", 64'(bus_if.out_valid), 64'(0));
      check("rst_bit_ready", 64'(bus_if.bit_ready), 64'(1));
      check("rst_np",        64'(bus_if.np),        64'(0));
      check("rst_state",     64'(dbg_state),        64'(0));
      reset = 1'b0;

      // 1: contiguous frame, out_valid the cycle after the 41st bit
      t0 = cyc;
      send_frame(32'h8000_0001, 8'h0F, 1'b1, 0, acc);
      check("t1_latency",   64'(cyc - t0),           64'(41));
      check("t1_out_valid", 64'(bus_if.out_valid),   64'(1));
      check("t1_np",        64'(bus_if.np),          64'h8000_0001);
      check("t1_vip",       64'(bus_if.vip),         64'h0F);
      check("t1_np_cnt",    64'(bus_if.np_cnt),      64'(2));
      check("t1_vip_cnt",   64'(bus_if.vip_cnt),     64'(4));
      check("t1_vvip",      64'(bus_if.vvip),        64'(1));

      // 2: stall in S_HOLD with bits offered, then release
      for (int i = 0; i < 10; i++) begin
         bus_if.bit_valid = 1'b1;
         bus_if.bit_in    = 1'($urandom_range(0, 1));
         tick();
         check("t2_bit_ready", 64'(bus_if.bit_ready), 64'(0));
         check("t2_np_stable", 64'(bus_if.np),        64'h8000_0001);
         check("t2_out_valid", 64'(bus_if.out_valid), 64'(1));
      end
      handshake();
      bus_if.bit_valid = 1'b0;
      check("t2_after_valid", 64'(bus_if.out_valid), 64'(0));
      check("t2_after_np",    64'(bus_if.np),        64'(0));
      check("t2_after_cnt",   64'(bus_if.np_cnt),    64'(0));
      check("t2_after_vvip",  64'(bus_if.vvip),      64'(0));

      // 3: gapped all-ones frame
      send_frame(32'hFFFF_FFFF, 8'hFF, 1'b1, 2, acc);
      check("t3_np",      64'(bus_if.np),      64'hFFFF_FFFF);
      check("t3_vip",     64'(bus_if.vip),     64'hFF);
      check("t3_np_cnt",  64'(bus_if.np_cnt),  64'(32));
      check("t3_vip_cnt", 64'(bus_if.vip_cnt), 64'(8));
      check("t3_vvip",    64'(bus_if.vvip),    64'(1));
      handshake();

      // 4: clear after 20 np bits (bit offered in the clear cycle), then zeros
      for (int i = 0; i < 20; i++) send_bit(1'b1, acc);
      bus_if.clear     = 1'b1;
      bus_if.bit_valid = 1'b1;
      bus_if.bit_in    = 1'b1;
      tick();
      bus_if.clear     = 1'b0;
      bus_if.bit_valid = 1'b0;
      check("t4_clr_np",    64'(bus_if.np),     64'(0));
      check("t4_clr_cnt",   64'(bus_if.np_cnt), 64'(0));
      check("t4_clr_state", 64'(dbg_state),     64'(0));
      send_frame(32'h0, 8'h0, 1'b0, 0, acc);
      check("t4_np",        64'(bus_if.np),        64'(0));
      check("t4_np_cnt",    64'(bus_if.np_cnt),    64'(0));
      check("t4_vip_cnt",   64'(bus_if.vip_cnt),   64'(0));
      check("t4_out_valid", 64'(bus_if.out_valid), 64'(1));
      // clear in S_HOLD together with out_ready drops the frame
      bus_if.clear     = 1'b1;
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.clear     = 1'b0;
      bus_if.out_ready = 1'b0;
      check("t4_hold_clr_valid", 64'(bus_if.out_valid), 64'(0));

      // 5: reset while in S_VIP with out_ready=1
      for (int i = 0; i < 32; i++) send_bit(i[0], acc);
      for (int i = 0; i < 3; i++)  send_bit(1'b1, acc);
      check("t5_pre_state",   64'(dbg_state),       64'(1));
      check("t5_pre_vip_cnt", 64'(bus_if.vip_cnt),  64'(3));
      reset            = 1'b1;
      bus_if.out_ready = 1'b1;
      bus_if.bit_valid = 1'b1;
      tick();
      reset            = 1'b0;
      bus_if.out_ready = 1'b0;
      bus_if.bit_valid = 1'b0;
      check("t5_state",     64'(dbg_state),        64'(0));
      check("t5_np",        64'(bus_if.np),        64'(0));
      check("t5_vip",       64'(bus_if.vip),       64'(0));
      check("t5_vip_cnt",   64'(bus_if.vip_cnt),   64'(0));
      check("t5_out_valid", 64'(bus_if.out_valid), 64'(0));
      check("t5_bit_ready", 64'(bus_if.bit_ready), 64'(1));

      // 6: back-to-back frames with out_ready tied high
      bus_if.out_ready = 1'b1;
      send_frame(32'h1234_5678, 8'hA5, 1'b0, 0, acc);
      a_end = cyc;
      check("t6a_out_valid", 64'(bus_if.out_valid), 64'(1));
      check("t6a_np",        64'(bus_if.np),        64'h1234_5678);
      check("t6a_np_cnt",    64'(bus_if.np_cnt),    64'(13));
      check("t6a_vip_cnt",   64'(bus_if.vip_cnt),   64'(4));
      check("t6a_vvip",      64'(bus_if.vvip),      64'(0));
      send_frame(32'hFFFF_0000, 8'h80, 1'b1, 0, acc);
      check("t6_handoff",    64'(acc - a_end),      64'(2));
      check("t6b_out_valid", 64'(bus_if.out_valid), 64'(1));
      check("t6b_np",        64'(bus_if.np),        64'hFFFF_0000);
      check("t6b_np_cnt",    64'(bus_if.np_cnt),    64'(16));
      check("t6b_vip_cnt",   64'(bus_if.vip_cnt),   64'(1));
      check("t6b_vvip",      64'(bus_if.vvip),      64'(1));
      tick();
      bus_if.out_ready = 1'b0;
      check("t6b_one_cycle", 64'(bus_if.out_valid), 64'(0));

      repeat (2) tick();
      check("sb_drained", 64'(exp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global bound so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
